// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle for the register-file write arbiter: offer, grant,
// destination register, write data and the global hold.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
);

  // Handshake: requester i raises req_valid[i] with req_reg/req_data slice i
  // and keeps all three stable until req_ready[i] is seen high at a rising
  // edge; that edge is the transfer. req_ready never depends on req_data.
  logic                      hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (
    output hold,
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  hold,
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ write-back requesters and
// tracks pending writes. Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  regfile_write_arbiter_if.slave   req,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_reg,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_write_reg,
  output logic [DATA_W-1:0]        rf_write_data,
  output logic [(2**ADDR_W)-1:0]   pending
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]       base;
  logic [NUM_REQ-1:0]     grant;
  logic                   grant_any;
  logic                   transfer;
  logic [ADDR_W-1:0]      sel_reg;
  logic [DATA_W-1:0]      sel_data;
  logic [(2**ADDR_W)-1:0] pending_next;

  // First valid requester at or above base, wrapping modulo NUM_REQ.
  always_comb begin
    int                 cand;
    logic [PTR_W-1:0]   cand_idx;
    grant     = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(base) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!grant_any && req.req_valid[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  assign req.req_ready = (req.hold || reset) ? '0 : grant;
  assign transfer      = grant_any && !req.hold && !reset;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_reg  = req.req_reg[k*ADDR_W +: ADDR_W];
        sel_data = req.req_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr;
    if (transfer) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[k]) ptr_next = PTR_W'((k + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

  assign base = ptr;
`endif

  // Register 0 is hardwired: its writes are accepted but never reach the file.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_write      <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      rf_write <= transfer && (sel_reg != '0);
      if (transfer && (sel_reg != '0)) begin
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
      end
    end
  end

  // A reservation on the same edge as the commit wins, so it is applied last.
  always_comb begin
    pending_next = pending;
    if (rf_write) pending_next[rf_write_reg] = 1'b0;
    if (rsv_valid && (rsv_reg != '0)) pending_next[rsv_reg] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then randomized
// traffic against a cycle-level reference model, including a mid-run reset.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int NREG    = 2**ADDR_W;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_reg;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [NREG-1:0]   pending;

  regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (bus),
    .rsv_valid     (rsv_valid),
    .rsv_reg       (rsv_reg),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .pending       (pending)
  );

  always #5 clock = ~clock;

  // Stimulus state owned by the bench
  logic              h;
  logic [NUM_REQ-1:0] v;
  logic [ADDR_W-1:0] r [NUM_REQ];
  logic [DATA_W-1:0] d [NUM_REQ];
  logic              rv;
  logic [ADDR_W-1:0] rr;

  // Reference model state
  int                m_ptr;
  logic              m_wr;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;
  logic [NREG-1:0]   m_pend;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              h;
    logic [2:0]        v;
    logic [3:0]        r0, r1, r2;
    logic [15:0]       d0, d1, d2;
    logic              rv;
    logic [3:0]        rr;
    logic [2:0]        e_rdy;
    logic              e_wr;
    logic [3:0]        e_wreg;
    logic [15:0]       e_wdata;
    logic [15:0]       e_pend;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic hh, input logic [2:0] vv,
                              input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                              input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                              input logic rvv, input logic [3:0] rrr,
                              input logic [2:0] erdy, input logic ewr, input logic [3:0] ewreg,
                              input logic [15:0] ewdata, input logic [15:0] epend);
    vec_t t;
    t.h = hh; t.v = vv; t.r0 = a0; t.r1 = a1; t.r2 = a2;
    t.d0 = b0; t.d1 = b1; t.d2 = b2; t.rv = rvv; t.rr = rrr;
    t.e_rdy = erdy; t.e_wr = ewr; t.e_wreg = ewreg; t.e_wdata = ewdata; t.e_pend = epend;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.hold      = h;
    bus.req_valid = v;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_reg[k*ADDR_W +: ADDR_W]  = r[k];
      bus.req_data[k*DATA_W +: DATA_W] = d[k];
    end
    rsv_valid = rv;
    rsv_reg   = rr;
  endtask

  // Winner of the current cycle by the arbitration rule, or -1 for none.
  function automatic int model_grant();
    int start;
    if (h || reset) return -1;
    start = FIXED ? 0 : m_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    logic [NREG-1:0] np;
    if (reset) begin
      m_ptr = 0; m_wr = 1'b0; m_wreg = '0; m_wdata = '0; m_pend = '0;
      return;
    end
    np = m_pend;
    if (m_wr) np[m_wreg] = 1'b0;
    if (rv && rr != 0) np[rr] = 1'b1;
    m_pend = np;
    if (g >= 0) begin
      m_wr = (r[g] != 0);
      if (m_wr) begin
        m_wreg  = r[g];
        m_wdata = d[g];
      end
      m_ptr = (g + 1) % NUM_REQ;
    end else begin
      m_wr = 1'b0;
    end
  endtask

  task automatic check_model(input int g);
    logic [NUM_REQ-1:0] erdy;
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    check("rand_ready",    32'(bus.req_ready), 32'(erdy));
    check("rand_rf_write", 32'(rf_write),      32'(m_wr));
    check("rand_wreg",     32'(rf_write_reg),  32'(m_wreg));
    check("rand_wdata",    32'(rf_write_data), 32'(m_wdata));
    check("rand_pending",  32'(pending),       32'(m_pend));
  endtask

  initial begin
    int g;

    // Directed table: inputs per cycle and hand-derived outputs for that cycle
    tbl[0]  = mk(0, 3'b001, 5,0,0, 16'h1234,0,0,            0,0, 3'b001, 0,0,16'h0000,16'h0000);
    tbl[1]  = mk(0, 3'b000, 5,0,0, 16'h1234,0,0,            0,0, 3'b000, 1,5,16'h1234,16'h0000);
    tbl[2]  = mk(0, 3'b100, 5,0,0, 16'h1234,0,16'hFFFF,     1,0, 3'b100, 0,5,16'h1234,16'h0000);
    tbl[3]  = mk(0, 3'b000, 5,0,0, 16'h1234,0,16'hFFFF,     0,0, 3'b000, 0,5,16'h1234,16'h0000);
    tbl[4]  = mk(0, 3'b111, 1,2,3, 16'h1111,16'h2222,16'h3333, 0,0, 3'b001, 0,5,16'h1234,16'h0000);
    tbl[5]  = mk(0, 3'b111, 1,2,3, 16'h1111,16'h2222,16'h3333, 0,0, FIXED ? 3'b001 : 3'b010,
                 1,1,16'h1111,16'h0000);
    tbl[6]  = mk(0, 3'b111, 1,2,3, 16'h1111,16'h2222,16'h3333, 0,0, FIXED ? 3'b001 : 3'b100,
                 1, FIXED ? 4'd1 : 4'd2, FIXED ? 16'h1111 : 16'h2222, 16'h0000);
    tbl[7]  = mk(0, 3'b111, 1,2,3, 16'h1111,16'h2222,16'h3333, 0,0, 3'b001,
                 1, FIXED ? 4'd1 : 4'd3, FIXED ? 16'h1111 : 16'h3333, 16'h0000);
    tbl[8]  = mk(0, 3'b000, 1,2,3, 16'h1111,16'h2222,16'h3333, 0,0, 3'b000, 1,1,16'h1111,16'h0000);
    tbl[9]  = mk(0, 3'b000, 1,2,3, 16'h1111,16'h2222,16'h3333, 1,7, 3'b000, 0,1,16'h1111,16'h0000);
    tbl[10] = mk(0, 3'b010, 1,7,3, 16'h1111,16'h7777,16'h3333, 0,0, 3'b010, 0,1,16'h1111,16'h0080);
    tbl[11] = mk(0, 3'b000, 1,7,3, 16'h1111,16'h7777,16'h3333, 0,0, 3'b000, 1,7,16'h7777,16'h0080);
    tbl[12] = mk(0, 3'b000, 1,7,3, 16'h1111,16'h7777,16'h3333, 0,0, 3'b000, 0,7,16'h7777,16'h0000);
    tbl[13] = mk(0, 3'b100, 1,7,3, 16'h1111,16'h7777,16'h0333, 1,3, 3'b100, 0,7,16'h7777,16'h0000);
    tbl[14] = mk(0, 3'b000, 1,7,3, 16'h1111,16'h7777,16'h0333, 1,3, 3'b000, 1,3,16'h0333,16'h0008);
    tbl[15] = mk(0, 3'b000, 1,7,3, 16'h1111,16'h7777,16'h0333, 0,0, 3'b000, 0,3,16'h0333,16'h0008);
    tbl[16] = mk(1, 3'b011, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, 3'b000, 0,3,16'h0333,16'h0008);
    tbl[17] = mk(1, 3'b011, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, 3'b000, 0,3,16'h0333,16'h0008);
    tbl[18] = mk(0, 3'b011, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, 3'b001, 0,3,16'h0333,16'h0008);
    tbl[19] = mk(0, 3'b010, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, 3'b010, 1,4,16'h0444,16'h0008);
    tbl[20] = mk(0, 3'b000, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, 3'b000, 1,5,16'h0555,16'h0008);
    tbl[21] = mk(0, 3'b011, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, 3'b001, 0,5,16'h0555,16'h0008);
    tbl[22] = mk(0, 3'b011, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, FIXED ? 3'b001 : 3'b010,
                 1,4,16'h0444,16'h0008);
    tbl[23] = mk(0, 3'b000, 4,5,3, 16'h0444,16'h0555,16'h0333, 0,0, 3'b000,
                 1, FIXED ? 4'd4 : 4'd5, FIXED ? 16'h0444 : 16'h0555, 16'h0008);

    // Reset with every input active
    h = 1'b0; v = '1; rv = 1'b1; rr = 4'd9;
    for (int k = 0; k < NUM_REQ; k++) begin
      r[k] = 4'(k + 1);
      d[k] = 16'hA5A5;
    end
    drive();
    model_edge(-1);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("reset_ready",    32'(bus.req_ready), 32'h0);
    check("reset_rf_write", 32'(rf_write),      32'h0);
    check("reset_wreg",     32'(rf_write_reg),  32'h0);
    check("reset_wdata",    32'(rf_write_data), 32'h0);
    check("reset_pending",  32'(pending),       32'h0);
    @(negedge clock);
    reset = 1'b0;
    v = '0; rv = 1'b0; rr = '0;
    drive();
    @(posedge clock);
    model_edge(-1);
    @(negedge clock);

    // Directed vectors
    for (int i = 0; i < 24; i++) begin
      h = tbl[i].h; v = tbl[i].v; rv = tbl[i].rv; rr = tbl[i].rr;
      r[0] = tbl[i].r0; r[1] = tbl[i].r1; r[2] = tbl[i].r2;
      d[0] = tbl[i].d0; d[1] = tbl[i].d1; d[2] = tbl[i].d2;
      drive();
      g = model_grant();
      #1;
      check($sformatf("vec%0d_ready", i),    32'(bus.req_ready), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d_rf_write", i), 32'(rf_write),      32'(tbl[i].e_wr));
      check($sformatf("vec%0d_wreg", i),     32'(rf_write_reg),  32'(tbl[i].e_wreg));
      check($sformatf("vec%0d_wdata", i),    32'(rf_write_data), 32'(tbl[i].e_wdata));
      check($sformatf("vec%0d_pending", i),  32'(pending),       32'(tbl[i].e_pend));
      @(posedge clock);
      model_edge(g);
      @(negedge clock);
    end

    // Randomized traffic; requesters hold their offer until granted
    v = '0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!v[k] && $urandom_range(0, 1) == 1) begin
          v[k] = 1'b1;
          r[k] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, NREG - 1));
          d[k] = 16'($urandom);
        end
      end
      h  = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 1) == 1) ? r[$urandom_range(0, NUM_REQ - 1)]
                                       : 4'($urandom_range(0, NREG - 1));
      drive();
      g = model_grant();
      #1;
      check_model(g);
      if (c == 300) begin
        #1 reset = 1'b1;
        #1;
        check("midreset_ready",    32'(bus.req_ready), 32'h0);
        check("midreset_rf_write", 32'(rf_write),      32'h0);
        check("midreset_pending",  32'(pending),       32'h0);
        @(posedge clock);
        model_edge(-1);
        @(negedge clock);
        reset = 1'b0;
      end else begin
        @(posedge clock);
        model_edge(g);
        if (g >= 0) v[g] = 1'b0;
        @(negedge clock);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
